// File: rtl/asrm_mem_bridge_if.sv
// CPU-side memory bus plus TX byte stream for asrm_mem_bridge.
// master: CPU/consumer side; slave: the bridge.
interface asrm_mem_bridge_if #(
   parameter int unsigned wordsize = 16
);
   logic [wordsize-1:0] addr;
   logic [wordsize-1:0] cpu_wdata;
   logic                write_en;
   logic [wordsize-1:0] cpu_rdata;
   logic [7:0]          tx_data;
   logic                tx_valid;
   logic                tx_ready;
   logic                fifo_full;

   modport master (
      output addr, cpu_wdata, write_en, tx_ready,
      input  cpu_rdata, tx_data, tx_valid, fifo_full
   );

   modport slave (
      input  addr, cpu_wdata, write_en, tx_ready,
      output cpu_rdata, tx_data, tx_valid, fifo_full
   );
endinterface

// File: rtl/asrm_mem_bridge.sv
// Memory stage behind the CPU RAM port: word RAM plus an I/O window holding a
// byte TX FIFO and a cycle counter. Reads are registered (1-cycle latency).
// Optional macro ASRM_CYCLE_COUNTER_EN adds the cycle counter and HI shadow;
// without it CYCLE_LO/CYCLE_HI read 0.
module asrm_mem_bridge #(
   parameter int unsigned wordsize        = 16,
   parameter int unsigned ram_depth_log2  = 10,
   parameter int unsigned fifo_depth_log2 = 3,
   parameter logic [15:0] io_base         = 16'hFF00
) (
   input logic             clk,
   input logic             reset,
   asrm_mem_bridge_if.slave bus
);
   localparam int unsigned RamDepth  = 1 << ram_depth_log2;
   localparam int unsigned FifoDepth = 1 << fifo_depth_log2;
   localparam int unsigned CntW      = fifo_depth_log2 + 1;
   localparam logic [wordsize-1:0] IoBaseExt = wordsize'(io_base);

   logic [wordsize-1:0]       ram_mem [RamDepth];
   logic [ram_depth_log2-1:0] ram_idx;
   logic                      is_io;
   logic [wordsize-1:0]       io_off;
   logic                      sel_tx, sel_stat, sel_lo, sel_hi;

   logic [7:0]                 fifo_mem [FifoDepth];
   logic [fifo_depth_log2-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]            count_q;
   logic                       ovf_q;
   logic                       full, empty;
   logic                       first_wr, push, push_ok, ovf_set, clr_ovf, pop;

   logic                prev_we_q;
   logic [wordsize-1:0] prev_addr_q;
   logic [wordsize-1:0] rdata_q, rdata_d;
   logic [wordsize-1:0] status;
   logic [wordsize-1:0] cyc_lo, cyc_hi;

   assign ram_idx  = bus.addr[ram_depth_log2-1:0];
   assign is_io    = bus.addr >= IoBaseExt;
   assign io_off   = bus.addr - IoBaseExt;
   assign sel_tx   = is_io && (io_off == wordsize'(0));
   assign sel_stat = is_io && (io_off == wordsize'(1));
   assign sel_lo   = is_io && (io_off == wordsize'(2));
   assign sel_hi   = is_io && (io_off == wordsize'(3));

   // A held write_en on one address is a single access for side-effecting I/O.
   assign first_wr = bus.write_en && !(prev_we_q && (prev_addr_q == bus.addr));
   assign full     = count_q == CntW'(FifoDepth);
   assign empty    = count_q == '0;
   assign pop      = !empty && bus.tx_ready;
   assign push     = first_wr && sel_tx;
   assign push_ok  = push && (!full || pop);
   assign ovf_set  = push && full && !pop;
   assign clr_ovf  = first_wr && sel_stat;

`ifdef ASRM_CYCLE_COUNTER_EN
   logic [2*wordsize-1:0] cycle_q;
   logic [wordsize-1:0]   shadow_q;
   logic                  addr_changed;

   assign addr_changed = prev_addr_q != bus.addr;

   // Free-running counter; HI half snapshotted once per fresh CYCLE_LO access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_q  <= '0;
         shadow_q <= '0;
      end else begin
         cycle_q <= cycle_q + 1'b1;
         if (sel_lo && addr_changed) shadow_q <= cycle_q[2*wordsize-1:wordsize];
      end
   end

   assign cyc_lo = cycle_q[wordsize-1:0];
   assign cyc_hi = shadow_q;
`else
   assign cyc_lo = '0;
   assign cyc_hi = '0;
`endif

   // STATUS word: full, empty, sticky overflow, occupancy in [7:4].
   always_comb begin
      status      = '0;
      status[0]   = full;
      status[1]   = empty;
      status[2]   = ovf_q;
      status[7:4] = 4'(count_q);
   end

   // Read mux; a same-cycle RAM write is forwarded (write-first).
   always_comb begin
      rdata_d = '0;
      if (!is_io) rdata_d = bus.write_en ? bus.cpu_wdata : ram_mem[ram_idx];
      else if (sel_stat) rdata_d = status;
      else if (sel_lo) rdata_d = cyc_lo;
      else if (sel_hi) rdata_d = cyc_hi;
   end

   // Word RAM: no reset, no de-duplication needed.
   always_ff @(posedge clk) begin
      if (reset && bus.write_en && !is_io) ram_mem[ram_idx] <= bus.cpu_wdata;
   end

   // FIFO storage, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (reset && push_ok) fifo_mem[wr_ptr_q] <= bus.cpu_wdata[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (ovf_set) ovf_q <= 1'b1;
         else if (clr_ovf) ovf_q <= 1'b0;
      end
   end

   // Registered read data and previous-access tracking.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata_q     <= '0;
         prev_we_q   <= 1'b0;
         prev_addr_q <= '0;
      end else begin
         rdata_q     <= rdata_d;
         prev_we_q   <= bus.write_en;
         prev_addr_q <= bus.addr;
      end
   end

   assign bus.cpu_rdata = rdata_q;
   assign bus.tx_valid  = !empty;
   assign bus.tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr_q];
   assign bus.fifo_full = full;
endmodule

// File: tb/tb_asrm_mem_bridge.sv
// Randomized + directed bench for asrm_mem_bridge against a transaction-level model.
module tb_asrm_mem_bridge;
`ifdef ASRM_CYCLE_COUNTER_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif
   localparam logic [15:0] IoBase = 16'hFF00;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   asrm_mem_bridge_if #(.wordsize(16)) bus ();

   asrm_mem_bridge #(
      .wordsize(16), .ram_depth_log2(10), .fifo_depth_log2(3), .io_base(IoBase)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference state
   logic [15:0] ram_m [1024];
   bit          ram_ok [1024];
   logic [7:0]  q [$];
   bit          m_ovf;
   logic [31:0] m_cnt;
   logic [15:0] m_shadow;
   logic [15:0] m_rd;
   bit          m_rd_ok;
   bit          m_pwe;
   logic [15:0] m_pa;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] status_of();
      logic [15:0] s = '0;
      s[0]   = q.size() == 8;
      s[1]   = q.size() == 0;
      s[2]   = m_ovf;
      s[7:4] = 4'(q.size());
      return s;
   endfunction

   task automatic model_tick(input logic [15:0] a, input logic [15:0] wd, input bit we,
                             input bit rdy, input bit rst);
      bit          full, pop, io, first, do_push;
      logic [15:0] off;
      if (!rst) begin
         q.delete();
         m_ovf = 0; m_cnt = 0; m_shadow = 0; m_rd = 0; m_rd_ok = 1; m_pwe = 0; m_pa = 0;
         return;
      end
      full    = q.size() == 8;
      pop     = rdy && q.size() > 0;
      io      = a >= IoBase;
      off     = a - IoBase;
      first   = we && !(m_pwe && m_pa == a);
      do_push = 0;
      m_rd_ok = 1;
      if (!io) begin
         if (we) m_rd = wd;
         else begin
            m_rd    = ram_m[a % 1024];
            m_rd_ok = ram_ok[a % 1024];
         end
         if (we) begin
            ram_m[a % 1024]  = wd;
            ram_ok[a % 1024] = 1;
         end
      end else begin
         case (off)
            16'd1:   m_rd = status_of();
            16'd2:   m_rd = CntEn ? m_cnt[15:0] : 16'h0;
            16'd3:   m_rd = m_shadow;
            default: m_rd = 16'h0;
         endcase
         if (CntEn && off == 16'd2 && m_pa != a) m_shadow = m_cnt[31:16];
         if (off == 16'd0 && first) begin
            if (full && !pop) m_ovf = 1;
            else do_push = 1;
         end
         if (off == 16'd1 && first) m_ovf = 0;
      end
      if (pop) void'(q.pop_front());
      if (do_push) q.push_back(wd[7:0]);
      if (CntEn) m_cnt = m_cnt + 1;
      m_pa  = a;
      m_pwe = we;
   endtask

   task automatic step(input logic [15:0] a, input logic [15:0] wd, input bit we,
                       input bit rdy, input bit rst);
      bus.addr      = a;
      bus.cpu_wdata = wd;
      bus.write_en  = we;
      bus.tx_ready  = rdy;
      reset         = rst;
      @(posedge clk);
      model_tick(a, wd, we, rdy, rst);
      #1;
      if (m_rd_ok) check("cpu_rdata", bus.cpu_rdata, m_rd);
      check("tx_valid", bus.tx_valid, q.size() > 0);
      check("tx_data", bus.tx_data, q.size() > 0 ? q[0] : 8'h00);
      check("fifo_full", bus.fifo_full, q.size() == 8);
   endtask

   task automatic idle(input bit rdy);
      step(16'h0000, 16'h0000, 0, rdy, 1);
   endtask

   initial begin
      logic [15:0] a, wd;
      bit          we;
      for (int i = 0; i < 1024; i++) ram_ok[i] = 0;
      a  = 0;
      we = 0;

      // Reset state
      step(16'h0, 16'h0, 0, 0, 0);
      step(16'h0, 16'h0, 0, 0, 0);
      check("rst_rdata", bus.cpu_rdata, 16'h0);
      check("rst_tx_valid", bus.tx_valid, 1'b0);
      check("rst_tx_data", bus.tx_data, 8'h00);
      check("rst_full", bus.fifo_full, 1'b0);

      // RAM write/read and aliasing
      step(16'd5, 16'h1234, 1, 0, 1);
      step(16'd5, 16'h0000, 0, 0, 1);
      check("ram_rd5", bus.cpu_rdata, 16'h1234);
      step(16'd5 + 16'd1024, 16'h0000, 0, 0, 1);
      check("ram_alias", bus.cpu_rdata, 16'h1234);

      // Held write_en on TX: one push only
      repeat (3) step(IoBase, 16'h0041, 1, 0, 1);
      idle(0);
      check("dedup_valid", bus.tx_valid, 1'b1);
      check("dedup_data", bus.tx_data, 8'h41);
      step(IoBase + 16'd1, 16'h0, 0, 0, 1);
      check("dedup_count", bus.cpu_rdata[7:4], 4'd1);
      idle(1);

      // Fill with 9 distinct pushes, ninth overflows
      for (int i = 0; i < 9; i++) begin
         step(IoBase, 16'(i), 1, 0, 1);
         idle(0);
      end
      check("full_flag", bus.fifo_full, 1'b1);
      step(IoBase + 16'd1, 16'h0, 0, 0, 1);
      check("status_ovf", bus.cpu_rdata, 16'h0085);
      step(IoBase + 16'd1, 16'h0, 1, 0, 1);
      step(IoBase + 16'd1, 16'h0, 0, 0, 1);
      check("status_clr", bus.cpu_rdata, 16'h0081);

      // Push + pop while full
      step(IoBase, 16'h00AA, 1, 1, 1);
      check("pp_full", bus.fifo_full, 1'b1);
      check("pp_head", bus.tx_data, 8'h01);
      step(IoBase + 16'd1, 16'h0, 0, 0, 1);
      check("pp_status", bus.cpu_rdata, 16'h0081);

      // Reset with 3 bytes queued
      repeat (5) idle(1);
      check("pre_rst_count", 32'(q.size()), 32'd3);
      step(16'h0, 16'h0, 0, 0, 0);
      check("mid_rst_valid", bus.tx_valid, 1'b0);
      check("mid_rst_rdata", bus.cpu_rdata, 16'h0);
      step(IoBase + 16'd1, 16'h0, 0, 0, 1);
      check("post_rst_status", bus.cpu_rdata, 16'h0002);
      step(16'd5, 16'h0, 0, 0, 1);
      check("ram_keeps", bus.cpu_rdata, 16'h1234);

      // Cycle counter consistency across the 16-bit boundary
      step(16'h0, 16'h0, 0, 0, 0);
      if (CntEn) while (m_cnt != 32'h0000_FFFF) idle(0);
      step(IoBase + 16'd2, 16'h0, 0, 0, 1);
      check("cyc_lo", bus.cpu_rdata, CntEn ? 16'hFFFF : 16'h0000);
      step(IoBase + 16'd3, 16'h0, 0, 0, 1);
      check("cyc_hi", bus.cpu_rdata, 16'h0000);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            if ($urandom_range(0, 9) < 5) begin
               a = 16'($urandom_range(0, 63));
               if ($urandom_range(0, 1) == 1) a = a + 16'(1024 * $urandom_range(1, 60));
            end else begin
               a = IoBase + 16'($urandom_range(0, 5));
            end
            we = $urandom_range(0, 1) == 1;
         end
         wd = 16'($urandom);
         step(a, wd, we, $urandom_range(0, 3) == 0, $urandom_range(0, 299) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/asrm_mem_bridge.md
Name: asrm_mem_bridge

Overview:
Memory stage directly downstream of the CPU's RAM-connection port. It consumes addr, data_out and write_en, and returns data_in. It contains the on-chip word RAM plus a small memory-mapped I/O window. The I/O window holds a byte transmit FIFO (console/debug output) and a free-running cycle counter. Read latency is one clock, which fits inside the CPU's two-cycle not-ready window.

Parameters:
wordsize, 16, data/address width; must be >= 16
ram_depth_log2, 10, RAM holds 2^ram_depth_log2 words
fifo_depth_log2, 3, TX FIFO holds 2^fifo_depth_log2 bytes; legal range 1..3
io_base, 16'hFF00, first address of the I/O window (zero-extended to wordsize)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low
addr  input  wordsize  word address from the CPU
cpu_wdata  input  wordsize  write data (CPU data_out)
write_en  input  1  write strobe from the CPU
cpu_rdata  output  wordsize  read data (CPU data_in)
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO not empty
tx_ready  input  1  consumer accepts the head byte this cycle
fifo_full  output  1  FIFO full flag

Behaviour:
- Interface: reset and clk are as decided: reset is synchronous and active-low; clock is clk. All state updates on posedge clk.
- Decode: addr >= io_base selects I/O; otherwise RAM at index addr[ram_depth_log2-1:0]. Addresses above the RAM size alias.
- RAM read: cpu_rdata is registered and equals RAM[index] one clock after addr is presented. Reads happen every cycle.
- RAM write: on each posedge with write_en=1 and a RAM address, RAM[index] <= cpu_wdata.
  - The written value is visible on the next read (write-first on a same-address read).
  - RAM contents are not reset.
- I/O map (offset from io_base):
  - +0 TX: a write pushes cpu_wdata[7:0]; reads return 0.
  - +1 STATUS: bit0 full, bit1 empty, bit2 overflow (sticky), bits[7:4] occupancy count, other bits 0. Any write clears overflow.
  - +2 CYCLE_LO: read returns counter[wordsize-1:0] and snapshots counter[2*wordsize-1:wordsize] into the HI shadow.
  - +3 CYCLE_HI: read returns the shadow.
  - Other offsets read 0; writes to them are ignored.
- Write de-duplication: the CPU may hold write_en for more than one cycle on one access.
  - A FIFO push or overflow clear occurs only on the first cycle of a contiguous write_en-high run to the same I/O address.
  - Track this with a registered previous write_en and previous addr.
  - RAM writes need no de-duplication.
- I/O reads are registered like RAM reads (1-cycle latency).
  - A CYCLE_LO snapshot is taken once per address change, so a held address does not re-snapshot.
- FIFO:
  - Circular buffer with read/write pointers and count; pop = tx_valid & tx_ready.
  - Push when full and no pop: byte dropped, overflow <= 1.
  - Simultaneous push and pop when full: both accepted, count unchanged, no overflow.
  - Push when empty: tx_valid rises the next cycle (no bypass).
  - Pointers wrap modulo depth.
- Cycle counter: 2*wordsize bits, increments every cycle, wraps to 0.
- Reset (reset=0 at posedge):
  - FIFO empty, overflow=0, counter=0, shadow=0, cpu_rdata=0.
  - tx_valid=0, fifo_full=0, tx_data=0; previous-write tracking cleared.
  - Reset mid-push discards that push.

Optional Feature:
ASRM_CYCLE_COUNTER_EN
- Defined: cycle counter and HI shadow are implemented as above.
- Undefined: no counter or shadow registers exist; CYCLE_LO and CYCLE_HI read 0. All other behaviour is identical.

Test Plan:
- Write 16'h1234 to addr 5, then read addr 5 -> cpu_rdata=16'h1234 one clock after addr is presented. Read addr 5+2^10 -> 16'h1234 (alias).
- write_en held 3 cycles at io_base+0 with data 16'h0041 -> exactly one push; tx_valid=1 and tx_data=8'h41 on the following cycle; STATUS bits[7:4]=1.
- tx_ready=0, 9 distinct pushes (depth 8) -> fifo_full=1, STATUS=16'h0085 (count 8, overflow, full). Write to io_base+1 -> STATUS=16'h0081.
- FIFO full, push and tx_ready=1 in the same cycle -> count stays 8, overflow stays 0, head advances to the second byte.
- With ASRM_CYCLE_COUNTER_EN, counter preloaded via run to 32'h0000_FFFF, read CYCLE_LO then CYCLE_HI -> 16'hFFFF then 16'h0000 (consistent snapshot). Without the macro -> both read 0.
- Assert reset=0 for one cycle with FIFO holding 3 bytes -> tx_valid=0, STATUS=16'h0002, cpu_rdata=0. RAM word 5 still reads 16'h1234.
